// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer with RTS/CTS request-grant handshake.
// Frame: start bit, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
// Optional parity support is compiled in with `define UART_TX_PARITY_EN.
module uart_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              tck,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic              stop2_i,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
`endif
    output logic              tx_rts_n_o,
    input  logic              tx_cts_n_i,
    input  logic              tx_enable_i,
    output logic              tx_o,
    output logic              busy_o
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd5
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   baud_q, baud_d;
    logic [IDX_W-1:0]   bit_q, bit_d;
    logic               stop2_q, stop2_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic               tx_q, tx_d;
    logic               rts_n_q, rts_n_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic               par_en_q, par_en_d;
    logic               par_bit_q, par_bit_d;
`endif

    logic               baud_done;
    assign baud_done = (baud_q == '0);

    // Next-state and registered-output computation for the frame sequencer
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        div_d      = div_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        rts_n_d    = rts_n_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    // Frame parameters are frozen here for the whole frame
                    shift_d = data_i;
                    div_d   = baud_div_i;
                    stop2_d = stop2_i;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = parity_en_i;
                    par_bit_d = (^data_i) ^ parity_odd_i;
`endif
                    state_d = REQ;
                    rts_n_d = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            REQ: begin
                if (!tx_cts_n_i && tx_enable_i) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = div_q;
                end
            end

            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    baud_d  = div_q;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end

            DATA: begin
                if (baud_done) begin
                    baud_d = div_q;
                    if (bit_q == IDX_W'(DATA_W - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
`else
                        state_d    = STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
`endif
                    end else begin
                        bit_d   = bit_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    baud_d     = div_q;
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end
`endif

            STOP: begin
                if (baud_done) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                        baud_d     = div_q;
                    end else begin
                        // Back to IDLE with RTS released so flow control can re-arbitrate
                        state_d    = IDLE;
                        stop_cnt_d = 1'b0;
                        baud_d     = '0;
                        tx_d       = 1'b1;
                        rts_n_d    = 1'b1;
                        ready_d    = 1'b1;
                        busy_d     = 1'b0;
                    end
                end else begin
                    baud_d = baud_q - DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                rts_n_d = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            div_q      <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            rts_n_q    <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            rts_n_q    <= rts_n_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign tx_o       = tx_q;
    assign tx_rts_n_o = rts_n_q;
    assign ready_o    = ready_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a bit-level frame model.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;

    logic              tck;
    logic              rst_n;
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic [DIV_W-1:0]  baud_div_i;
    logic              stop2_i;
    logic              parity_en;
    logic              parity_odd;
    logic              tx_rts_n_o;
    logic              tx_cts_n_i;
    logic              tx_enable_i;
    logic              tx_o;
    logic              busy_o;

    int n_chk = 0;
    int n_err = 0;

    uart_tx #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .tck         (tck),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .baud_div_i  (baud_div_i),
        .stop2_i     (stop2_i),
`ifdef UART_TX_PARITY_EN
        .parity_en_i (parity_en),
        .parity_odd_i(parity_odd),
`endif
        .tx_rts_n_o  (tx_rts_n_o),
        .tx_cts_n_i  (tx_cts_n_i),
        .tx_enable_i (tx_enable_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"},    32'(tx_o), 32'd1);
        chk({tag, "_rts"},   32'(tx_rts_n_o), 32'd1);
        chk({tag, "_ready"}, 32'(ready_o), 32'd1);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
    endtask

    // Send one byte and check every cycle from acceptance to the first IDLE cycle
    task automatic send(input logic [7:0] d, input int div, input bit s2, input int wait_n,
                        input bit drop, input bit pe, input bit po);
        logic exp_q[$];
        int   per;
        int   k;
        int   ones;
        bit   use_par;
        per = div + 1;
`ifdef UART_TX_PARITY_EN
        use_par = pe;
`else
        use_par = 1'b0;
`endif
        k = 0;
        while (ready_o !== 1'b1 && k < 500) begin
            step();
            k++;
        end
        chk("ready_wait", 32'(ready_o), 32'd1);

        data_i      = d;
        baud_div_i  = DIV_W'(div);
        stop2_i     = s2;
        parity_en   = pe;
        parity_odd  = po;
        valid_i     = 1'b1;
        tx_cts_n_i  = (wait_n > 0);
        tx_enable_i = 1'b1;
        step();
        chk("acc_rts",   32'(tx_rts_n_o), 32'd0);
        chk("acc_ready", 32'(ready_o), 32'd0);
        chk("acc_busy",  32'(busy_o), 32'd1);
        chk("acc_tx",    32'(tx_o), 32'd1);
        valid_i = 1'b0;

        for (int i = 0; i < wait_n; i++) begin
            tx_enable_i = 1'($urandom_range(0, 1));
            data_i      = DATA_W'($urandom);
            baud_div_i  = DIV_W'($urandom);
            step();
            chk("req_rts",   32'(tx_rts_n_o), 32'd0);
            chk("req_tx",    32'(tx_o), 32'd1);
            chk("req_ready", 32'(ready_o), 32'd0);
        end
        tx_cts_n_i  = 1'b0;
        tx_enable_i = 1'b1;

        // Expected line waveform: each frame bit repeated for one bit period
        ones = 0;
        for (int b = 0; b < DATA_W; b++) ones += int'(d[b]);
        for (int c = 0; c < per; c++) exp_q.push_back(1'b0);
        for (int b = 0; b < DATA_W; b++)
            for (int c = 0; c < per; c++) exp_q.push_back(d[b]);
        if (use_par)
            for (int c = 0; c < per; c++) exp_q.push_back(1'((ones % 2) ^ int'(po)));
        for (int c = 0; c < per * (s2 ? 2 : 1); c++) exp_q.push_back(1'b1);

        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                valid_i    = 1'($urandom_range(0, 1));
                data_i     = DATA_W'($urandom);
                baud_div_i = DIV_W'($urandom);
                stop2_i    = 1'($urandom_range(0, 1));
                parity_en  = 1'($urandom_range(0, 1));
                parity_odd = 1'($urandom_range(0, 1));
            end
            if (drop && i == 4 * per) begin
                tx_cts_n_i  = 1'b1;
                tx_enable_i = 1'b0;
            end
            step();
            chk("frm_tx",    32'(tx_o), 32'(exp_q[i]));
            chk("frm_rts",   32'(tx_rts_n_o), 32'd0);
            chk("frm_busy",  32'(busy_o), 32'd1);
            chk("frm_ready", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        step();
        chk_idle("end");
    endtask

    initial begin
        rst_n       = 1'b0;
        valid_i     = 1'b1;
        data_i      = 8'h3C;
        baud_div_i  = '0;
        stop2_i     = 1'b0;
        parity_en   = 1'b0;
        parity_odd  = 1'b0;
        tx_cts_n_i  = 1'b0;
        tx_enable_i = 1'b1;

        // Reset held with valid asserted
        repeat (3) begin
            step();
            chk_idle("rst");
        end
        valid_i = 1'b0;
        rst_n   = 1'b1;
        step();
        chk_idle("post_rst");

        // Directed frames
        send(8'hA5, 3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        send(8'h3C, 1, 1'b0, 20, 1'b0, 1'b0, 1'b0);
        send(8'h00, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        send(8'h5A, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        send(8'h81, 2, 1'b1, 5, 1'b0, 1'b0, 1'b0);
`ifdef UART_TX_PARITY_EN
        send(8'h07, 1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        send(8'h07, 1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
`endif

        // Reset asserted in the middle of DATA
        data_i      = 8'h00;
        baud_div_i  = DIV_W'(3);
        stop2_i     = 1'b0;
        valid_i     = 1'b1;
        tx_cts_n_i  = 1'b0;
        tx_enable_i = 1'b1;
        step();
        valid_i = 1'b0;
        repeat (7) step();
        chk("mid_tx_low",  32'(tx_o), 32'd0);
        chk("mid_busy",    32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        @(posedge tck);
        #1 rst_n = 1'b1;
        step();
        chk_idle("mid_rel");

        // Randomized frames
        for (int n = 0; n < 25; n++) begin
            send(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
